// File: rtl/grad_step_scaler.sv
// Scales a vector of signed Q8.8 gradient components by a Q8.8 learning rate,
// one component per cycle through a single shared multiplier, with saturation.
module grad_step_scaler #(
  parameter int unsigned FRACT_BITS = 8,
  parameter int unsigned N_DIM      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*N_DIM-1:0]  grad_in,
  input  logic [15:0]          lr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*N_DIM-1:0]  step_out,
  output logic [N_DIM-1:0]     sat_flags
);

  localparam int unsigned IDX_W = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam logic signed [23:0] MAX_V = 24'sd32767;
  localparam logic signed [23:0] MIN_V = -24'sd32768;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [16*N_DIM-1:0] grad_q;
  logic [15:0]         lr_q;

  logic signed [15:0]  lane_c;
  logic signed [31:0]  prod_c;
  logic signed [23:0]  shifted_c;
  logic [15:0]         clamp_c;
  logic                sat_c;

  // Reset gates in_ready directly so nothing is accepted while rst is held.
  assign in_ready = (state == IDLE) && !rst;

  // Shared multiplier: floor-shift the product, then clamp to 16-bit range.
  always_comb begin
    lane_c    = grad_q[16*idx +: 16];
    prod_c    = lane_c * $signed(lr_q);
    shifted_c = 24'(prod_c >>> FRACT_BITS);
    clamp_c   = shifted_c[15:0];
    sat_c     = 1'b0;
    if (shifted_c > MAX_V) begin
      clamp_c = 16'h7FFF;
      sat_c   = 1'b1;
    end else if (shifted_c < MIN_V) begin
      clamp_c = 16'h8000;
      sat_c   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      grad_q    <= '0;
      lr_q      <= '0;
      step_out  <= '0;
      sat_flags <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            grad_q <= grad_in;
            lr_q   <= lr_in;
            idx    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          step_out[16*idx +: 16] <= clamp_c;
          sat_flags[idx]         <= sat_c;
          if (idx == IDX_W'(N_DIM - 1)) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grad_step_scaler.sv
// Directed self-checking bench for grad_step_scaler: latency, saturation,
// floor rounding, output hold, mid-vector reset and back-to-back throughput.
module tb_grad_step_scaler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] grad_in;
  logic [15:0] lr_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] step_out;
  logic [3:0]  sat_flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grad_step_scaler #(.FRACT_BITS(8), .N_DIM(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .grad_in   (grad_in),
    .lr_in     (lr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .step_out  (step_out),
    .sat_flags (sat_flags)
  );

  // Present a vector at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [63:0] g, input logic [15:0] lr);
    int t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    grad_in  = g;
    lr_in    = lr;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic [63:0] es, input logic [3:0] ef);
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL %s_latency got=%0d required=4", name, lat);
    end
    n_cmp++;
    if (step_out !== es) begin
      n_err++;
      $display("FAIL %s_step got=%h required=%h", name, step_out, es);
    end
    n_cmp++;
    if (sat_flags !== ef) begin
      n_err++;
      $display("FAIL %s_flags got=%b required=%b", name, sat_flags, ef);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    grad_in = '0; lr_in = '0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || step_out !== 64'h0 || sat_flags !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state rdy=%b vld=%b step=%h flags=%b required 0/0/0/0",
               in_ready, out_valid, step_out, sat_flags);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready got=%b required=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    send({16'h0200, 16'h0100, 16'hFE00, 16'h0000}, 16'h0080);
    wait_out(lat);
    check_result("basic", lat, {16'h0100, 16'h0080, 16'hFF00, 16'h0000}, 4'b0000);
    consume();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_return rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_saturation();
    int lat;
    send({16'h3FFF, 16'hC000, 16'h8000, 16'h7FFF}, 16'h0200);
    wait_out(lat);
    check_result("sat_pos_lr", lat, {16'h7FFE, 16'h8000, 16'h8000, 16'h7FFF}, 4'b0011);
    consume();
    send({16'h0000, 16'h7FFF, 16'h0100, 16'h8000}, 16'hFF00);
    wait_out(lat);
    check_result("sat_neg_lr", lat, {16'h0000, 16'h8001, 16'hFF00, 16'h7FFF}, 4'b0001);
    consume();
  endtask

  task automatic test_floor();
    int lat;
    send({16'h0101, 16'hFFFE, 16'h0001, 16'hFFFF}, 16'h0080);
    wait_out(lat);
    check_result("floor", lat, {16'h0080, 16'hFFFF, 16'h0000, 16'hFFFF}, 4'b0000);
    consume();
  endtask

  task automatic test_lr_zero(input logic [63:0] prev);
    int lat;
    send({16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF}, 16'h0000);
    n_cmp++;
    if (step_out !== prev) begin
      n_err++;
      $display("FAIL retain_prev got=%h required=%h", step_out, prev);
    end
    wait_out(lat);
    check_result("lr_zero", lat, 64'h0, 4'b0000);
    consume();
  endtask

  task automatic test_hold();
    int lat;
    logic [63:0] es;
    es = {16'h7FFF, 16'hFFBE, 16'h0FF3, 16'hEDCC};
    send({16'h8001, 16'h0042, 16'hF00D, 16'h1234}, 16'hFF00);
    wait_out(lat);
    check_result("neg_lr", lat, es, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      grad_in  = {$urandom, $urandom};
      lr_in    = 16'($urandom);
      in_valid = i[0];
      @(negedge clk);
      n_cmp++;
      if (step_out !== es || sat_flags !== 4'b0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d step=%h flags=%b vld=%b rdy=%b required %h/0000/1/0",
                 i, step_out, sat_flags, out_valid, in_ready, es);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL hold_handshake_ready got=%b required=0", in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    send({16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h0100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_ready_during got=%b required=0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (step_out !== 64'h0 || sat_flags !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_state step=%h flags=%b vld=%b rdy=%b required 0/0/0/1",
               step_out, sat_flags, out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL midrst_no_valid got=%0d pulses required=0", seen);
    end
    send({16'h0200, 16'h0100, 16'hFE00, 16'h0000}, 16'h0080);
    wait_out(lat);
    check_result("after_rst", lat, {16'h0100, 16'h0080, 16'hFF00, 16'h0000}, 4'b0000);
    consume();
  endtask

  task automatic test_back_to_back();
    logic [63:0] bg [3];
    logic [15:0] bl [3];
    logic [63:0] be [3];
    logic [3:0]  bf [3];
    int nv = 0;
    int nr = 0;
    int last = -1;
    bg[0] = {16'h6000, 16'h0001, 16'hFF00, 16'h0100}; bl[0] = 16'h0180;
    be[0] = {16'h7FFF, 16'h0001, 16'hFE80, 16'h0180}; bf[0] = 4'b1000;
    bg[1] = {16'h0000, 16'h8000, 16'h0003, 16'h0100}; bl[1] = 16'hFF80;
    be[1] = {16'h0000, 16'h4000, 16'hFFFE, 16'hFF80}; bf[1] = 4'b0000;
    bg[2] = {16'hFE00, 16'h0002, 16'hFF00, 16'h0100}; bl[2] = 16'h7FFF;
    be[2] = {16'h8000, 16'h00FF, 16'h8001, 16'h7FFF}; bf[2] = 4'b1000;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nr < 3; cyc++) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (step_out !== be[nr] || sat_flags !== bf[nr]) begin
          n_err++;
          $display("FAIL b2b_result%0d step=%h flags=%b required %h/%b",
                   nr, step_out, sat_flags, be[nr], bf[nr]);
        end
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != 6) begin
            n_err++;
            $display("FAIL b2b_spacing%0d got=%0d required=6", nr, cyc - last);
          end
        end
        last = cyc;
        nr++;
      end
      if (in_ready === 1'b1) begin
        if (nv < 3) begin
          grad_in  = bg[nv];
          lr_in    = bl[nv];
          in_valid = 1'b1;
          nv++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (nr != 3) begin
      n_err++;
      $display("FAIL b2b_count got=%0d required=3", nr);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    grad_in = '0; lr_in = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_floor();
    test_lr_zero({16'h0080, 16'hFFFF, 16'h0000, 16'hFFFF});
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grad_step_scaler.md
GRAD_STEP_SCALER -- requirements
Module: grad_step_scaler

Interface
REQ-001 Parameter FRACT_BITS, default 8, SHALL set the number of fractional bits of every Q8.8 operand and result.
REQ-002 Parameter N_DIM, default 4, SHALL set the number of gradient components per vector.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that grad_in and lr_in hold a vector to be scaled.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a vector this cycle.
REQ-007 grad_in  input  16*N_DIM  SHALL carry signed Q8.8 gradient components, component k in bits [16k+15:16k].
REQ-008 lr_in  input  16  SHALL carry the signed Q8.8 learning rate.
REQ-009 out_valid  output  1  SHALL indicate that step_out and sat_flags hold a completed result.
REQ-010 out_ready  input  1  SHALL indicate that the downstream subtract stage consumes the result this cycle.
REQ-011 step_out  output  16*N_DIM  SHALL carry signed Q8.8 steps (lr*grad), same packing as grad_in; each lane drives b_in of one capped-difference stage.
REQ-012 sat_flags  output  N_DIM  SHALL flag, per component, that the step was clamped.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DONE; in_ready = 1 only in IDLE and not in rst; out_valid = 1 only in DONE.
REQ-014 On an IDLE edge with in_valid=1, the block SHALL register grad_in and lr_in, clear idx to 0, and enter MUL; in_valid=0 SHALL leave it in IDLE.
REQ-015 Input values SHALL be sampled only on the accepting edge; later changes to grad_in/lr_in SHALL not affect the result.
REQ-016 In MUL, each edge SHALL compute one component idx using one shared signed 16x16 multiplier into a 32-bit product, then increment idx.
REQ-017 The product SHALL be arithmetically shifted right by FRACT_BITS (truncation toward negative infinity, no rounding) into a 24-bit intermediate.
REQ-018 If the intermediate > 0x7FFF, the lane SHALL be written 0x7FFF and its sat_flag set; if < -0x8000, written 0x8000 and flag set; otherwise written intermediate[15:0] and flag cleared.
REQ-019 On the edge writing component N_DIM-1 the FSM SHALL enter DONE; out_valid SHALL therefore first be high exactly N_DIM edges after the accepting edge (4 for default).
REQ-020 In DONE, step_out and sat_flags SHALL be held stable until the edge where out_ready=1, which SHALL return the FSM to IDLE.
REQ-021 out_valid SHALL never depend combinationally on out_ready; in_ready SHALL never depend combinationally on in_valid.
REQ-022 No new vector SHALL be accepted in the same cycle as the output handshake; in_ready rises the cycle after.
REQ-023 step_out and sat_flags SHALL retain the last result in IDLE and MUL until overwritten lane by lane.
REQ-024 lr_in of 0 SHALL yield all-zero steps with all flags clear; negative lr_in SHALL be legal and scaled identically.

Reset
REQ-025 With rst=1 at an edge, the FSM SHALL enter IDLE, idx=0, step_out=0, sat_flags=0, out_valid=0; in_ready SHALL be 0 while rst=1.
REQ-026 rst asserted in MUL or DONE SHALL abort the vector; no out_valid pulse SHALL follow, and in_ready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-027 grad={0x0200,0x0100,0xFE00,0x0000}, lr=0x0080 -> after 4 edges step_out={0x0100,0x0080,0xFF00,0x0000}, sat_flags=0.
REQ-028 grad lane0=0x7FFF, lane1=0x8000, lr=0x0200 -> lane0=0x7FFF, lane1=0x8000, flags[1:0]=2'b11; lane with grad=0x8000, lr=0xFF00 (-1.0) -> 0x7FFF, flag set.
REQ-029 grad lane0=0xFFFF, lr=0x0080 -> lane0=0xFFFF (floor of -0.5 LSB), flag clear.
REQ-030 out_ready held 0 for 10 cycles in DONE while grad_in/lr_in/in_valid toggle -> step_out, sat_flags, out_valid unchanged; in_ready stays 0; on out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-031 rst pulsed 1 cycle during MUL (idx=2) -> outputs zeroed, no out_valid; next accepted vector produces correct result with normal 4-edge latency.
REQ-032 Back-to-back vectors with in_valid and out_ready tied high -> one result per 6 cycles (accept, 4 MUL, DONE), every result matches a reference model.
